// File: rtl/ctrl_pipe_buf.sv
// Two-entry skid buffer for a pipeline control/data bundle, updated on the falling clock edge.
// Control fields read as a zero bubble when the head is empty; datapath fields keep their last value.
module ctrl_pipe_buf #(
  parameter int WB_SIZE  = 2,
  parameter int MEM_SIZE = 8,
  parameter int EX_SIZE  = 14,
  parameter int DATA_W   = 16,
  parameter int PC_W     = 32,
  parameter int REG_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WB_SIZE-1:0]  i_wb,
  input  logic [MEM_SIZE-1:0] i_mem,
  input  logic [EX_SIZE-1:0]  i_ex,
  input  logic                i_chg_flag,
  input  logic                i_out_wr,
  input  logic                i_int,
  input  logic [PC_W-1:0]     i_pc,
  input  logic [REG_W-1:0]    i_rsrc1,
  input  logic [REG_W-1:0]    i_rsrc2,
  input  logic [REG_W-1:0]    i_rdst,
  input  logic [DATA_W-1:0]   i_immd,
  input  logic [DATA_W-1:0]   i_rd1,
  input  logic [DATA_W-1:0]   i_rd2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WB_SIZE-1:0]  o_wb,
  output logic [MEM_SIZE-1:0] o_mem,
  output logic [EX_SIZE-1:0]  o_ex,
  output logic                o_chg_flag,
  output logic                o_out_wr,
  output logic                o_int,
  output logic [PC_W-1:0]     o_pc,
  output logic [REG_W-1:0]    o_rsrc1,
  output logic [REG_W-1:0]    o_rsrc2,
  output logic [REG_W-1:0]    o_rdst,
  output logic [DATA_W-1:0]   o_immd,
  output logic [DATA_W-1:0]   o_rd1,
  output logic [DATA_W-1:0]   o_rd2,
  output logic [1:0]          o_count
);

  localparam int CTL_W = WB_SIZE + MEM_SIZE + EX_SIZE + 3;
  localparam int DAT_W = PC_W + 3 * REG_W + 3 * DATA_W;
  localparam int ENT_W = CTL_W + DAT_W;

  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] main_ent;
  logic [ENT_W-1:0] skid_ent;
  logic             main_valid;
  logic             skid_valid;
  logic             in_fire;
  logic             out_fire;
  logic [CTL_W-1:0] main_ctl;

  assign in_ent = {i_wb, i_mem, i_ex, i_chg_flag, i_out_wr, i_int,
                   i_pc, i_rsrc1, i_rsrc2, i_rdst, i_immd, i_rd1, i_rd2};

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(negedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ent   <= '0;
      skid_ent   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (in_fire) begin
        main_ent   <= in_ent;
        main_valid <= 1'b1;
      end
    end else if (!skid_valid) begin
      if (out_fire) begin
        if (in_fire) main_ent <= in_ent;
        else         main_valid <= 1'b0;
      end else if (in_fire) begin
        skid_ent   <= in_ent;
        skid_valid <= 1'b1;
      end
    end else if (out_fire) begin
      main_ent   <= skid_ent;
      skid_valid <= 1'b0;
    end
  end

  // Control fields must not leak a stale command downstream when the head is empty.
  assign main_ctl = main_valid ? main_ent[ENT_W-1:DAT_W] : '0;

  assign {o_wb, o_mem, o_ex, o_chg_flag, o_out_wr, o_int} = main_ctl;
  assign {o_pc, o_rsrc1, o_rsrc2, o_rdst, o_immd, o_rd1, o_rd2} = main_ent[DAT_W-1:0];

  assign o_count = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_ctrl_pipe_buf.sv
// Bench for ctrl_pipe_buf: directed vectors feed a scoreboard queue, a posedge monitor pops and compares.
// Inputs change just after the falling (active) edge; everything is sampled on the rising edge.
module tb_ctrl_pipe_buf;

  typedef struct packed {
    logic [1:0]  wb;
    logic [7:0]  mem;
    logic [13:0] ex;
    logic        chg;
    logic        owr;
    logic        intr;
    logic [31:0] pc;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic [15:0] immd;
    logic [15:0] rd1;
    logic [15:0] rd2;
  } ent_t;

  localparam ent_t NONE = '0;

  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  ent_t cur;
  logic [1:0]  o_wb;
  logic [7:0]  o_mem;
  logic [13:0] o_ex;
  logic        o_chg_flag, o_out_wr, o_int;
  logic [31:0] o_pc;
  logic [2:0]  o_rsrc1, o_rsrc2, o_rdst;
  logic [15:0] o_immd, o_rd1, o_rd2;
  logic [1:0]  o_count;

  // second instance with widened execute and data fields
  logic        v2, rdy2, in_ready2, out_valid2;
  logic [31:0] d2_pc, d2_immd, d2_rd1, d2_rd2;
  logic [19:0] d2_ex;
  logic [1:0]  o2_wb;
  logic [7:0]  o2_mem;
  logic [19:0] o2_ex;
  logic        o2_chg_flag, o2_out_wr, o2_int;
  logic [31:0] o2_pc;
  logic [2:0]  o2_rsrc1, o2_rsrc2, o2_rdst;
  logic [31:0] o2_immd, o2_rd1, o2_rd2;
  logic [1:0]  o2_count;

  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  ent_t expq[$];

  ctrl_pipe_buf dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .i_wb(cur.wb), .i_mem(cur.mem), .i_ex(cur.ex), .i_chg_flag(cur.chg),
    .i_out_wr(cur.owr), .i_int(cur.intr), .i_pc(cur.pc), .i_rsrc1(cur.rs1),
    .i_rsrc2(cur.rs2), .i_rdst(cur.rd), .i_immd(cur.immd), .i_rd1(cur.rd1),
    .i_rd2(cur.rd2), .out_valid(out_valid), .out_ready(out_ready),
    .o_wb(o_wb), .o_mem(o_mem), .o_ex(o_ex), .o_chg_flag(o_chg_flag),
    .o_out_wr(o_out_wr), .o_int(o_int), .o_pc(o_pc), .o_rsrc1(o_rsrc1),
    .o_rsrc2(o_rsrc2), .o_rdst(o_rdst), .o_immd(o_immd), .o_rd1(o_rd1),
    .o_rd2(o_rd2), .o_count(o_count)
  );

  ctrl_pipe_buf #(.DATA_W(32), .EX_SIZE(20)) dut2 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(v2), .in_ready(in_ready2),
    .i_wb(cur.wb), .i_mem(cur.mem), .i_ex(d2_ex), .i_chg_flag(cur.chg),
    .i_out_wr(cur.owr), .i_int(cur.intr), .i_pc(d2_pc), .i_rsrc1(cur.rs1),
    .i_rsrc2(cur.rs2), .i_rdst(cur.rd), .i_immd(d2_immd), .i_rd1(d2_rd1),
    .i_rd2(d2_rd2), .out_valid(out_valid2), .out_ready(rdy2),
    .o_wb(o2_wb), .o_mem(o2_mem), .o_ex(o2_ex), .o_chg_flag(o2_chg_flag),
    .o_out_wr(o2_out_wr), .o_int(o2_int), .o_pc(o2_pc), .o_rsrc1(o2_rsrc1),
    .o_rsrc2(o2_rsrc2), .o_rdst(o2_rdst), .o_immd(o2_immd), .o_rd1(o2_rd1),
    .o_rd2(o2_rd2), .o_count(o2_count)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic ent_t mk(input logic [31:0] pc, input logic [15:0] immd);
    ent_t e;
    e.wb   = {1'b1, pc[0]};
    e.mem  = 8'hA5 ^ pc[7:0];
    e.ex   = 14'h2AAA ^ pc[13:0];
    e.chg  = pc[1];
    e.owr  = ~pc[0];
    e.intr = 1'b1;
    e.pc   = pc;
    e.rs1  = pc[2:0];
    e.rs2  = ~pc[2:0];
    e.rd   = pc[2:0] + 3'd1;
    e.immd = immd;
    e.rd1  = {pc[7:0], 8'hC3};
    e.rd2  = ~{pc[7:0], 8'hC3};
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One falling edge: apply inputs, then land on the following rising edge.
  task automatic step(input logic v, input ent_t e, input logic ordy,
                      input logic fl = 1'b0, input logic rs = 1'b0);
    @(negedge clk);
    #1;
    in_valid  = v;
    cur       = e;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(posedge clk);
    if (v && in_ready && !fl && !rs) expq.push_back(e);
  endtask

  always @(posedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      ent_t act, exp;
      act = {o_wb, o_mem, o_ex, o_chg_flag, o_out_wr, o_int,
             o_pc, o_rsrc1, o_rsrc2, o_rdst, o_immd, o_rd1, o_rd2};
      n_vec++;
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got pc %0h, expected no entry", o_pc);
      end else begin
        exp = expq.pop_front();
        if (act !== exp) begin
          n_err++;
          $display("FAIL scoreboard: got %0h, expected %0h", act, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t c;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; cur = mk(32'h7, 16'h1234);
    v2 = 1'b1; rdy2 = 1'b0; d2_pc = 32'h5; d2_ex = '1; d2_immd = '1; d2_rd1 = '1; d2_rd2 = '1;

    // reset held two cycles with input presented
    step(1, mk(32'h7, 16'h1234), 1, 0, 1);
    step(1, mk(32'h7, 16'h1234), 1, 0, 1);
    chk("rst_count", o_count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", {o_wb, o_mem, o_ex, o_chg_flag, o_out_wr, o_int, o_pc,
                        o_rsrc1, o_rsrc2, o_rdst, o_immd, o_rd1, o_rd2}, 0);
    chk("rst_dut2_count", o2_count, 0);
    v2 = 1'b0;
    step(0, NONE, 1);
    mon_en = 1'b1;

    // stream with out_ready high
    step(1, mk(32'h10, 16'h0010), 1);
    step(1, mk(32'h11, 16'h0011), 1);
    chk("stream_pc0", o_pc, 32'h10);
    chk("stream_cnt0", o_count, 1);
    step(1, mk(32'h12, 16'h0012), 1);
    chk("stream_pc1", o_pc, 32'h11);
    chk("stream_cnt1", o_count, 1);
    step(0, NONE, 1);
    chk("stream_pc2", o_pc, 32'h12);
    chk("stream_cnt2", o_count, 1);
    step(0, NONE, 1);
    chk("stream_empty", o_count, 0);

    // backpressure: A, B fill both entries, C waits
    c = mk(32'h22, 16'hBEEF);
    step(1, mk(32'h20, 16'h0020), 0);
    step(1, mk(32'h21, 16'h0021), 0);
    step(1, c, 0);
    chk("bp_count_full", o_count, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", o_pc, 32'h20);
    step(1, c, 1);
    chk("bp_held_off", in_ready, 0);
    step(1, c, 1);
    chk("bp_head_b", o_pc, 32'h21);
    chk("bp_in_ready_back", in_ready, 1);
    step(0, NONE, 1);
    chk("bp_replace_count", o_count, 1);
    chk("bp_head_c", o_pc, 32'h22);
    step(0, NONE, 1);

    // bubble after drain
    chk("bubble_valid", out_valid, 0);
    chk("bubble_mem", o_mem, 0);
    chk("bubble_int", o_int, 0);
    chk("bubble_immd_hold", o_immd, 16'hBEEF);
    chk("bubble_pc_hold", o_pc, 32'h22);

    // flush with both entries full and input presented
    step(1, mk(32'h30, 16'h0030), 0);
    step(1, mk(32'h31, 16'h0031), 0);
    step(1, mk(32'h32, 16'h0032), 0);
    chk("fl_pre_count", o_count, 2);
    step(1, mk(32'h33, 16'h0033), 0, 1);
    expq.delete();
    step(0, NONE, 1);
    chk("fl_valid", out_valid, 0);
    chk("fl_count", o_count, 0);
    chk("fl_ctl_zero", {o_ex, o_wb, o_mem}, 0);
    chk("fl_in_ready", in_ready, 1);
    // flush while empty and ready: input must still be dropped
    step(1, mk(32'h34, 16'h0034), 1, 1);
    step(0, NONE, 1);
    chk("fl_drop_empty", o_count, 0);

    // reset mid-operation
    step(1, mk(32'h40, 16'h0040), 0);
    step(1, mk(32'h41, 16'h0041), 0);
    step(0, NONE, 0);
    chk("mrst_pre_count", o_count, 2);
    step(1, mk(32'h42, 16'h0042), 0, 0, 1);
    expq.delete();
    step(0, NONE, 1);
    chk("mrst_count", o_count, 0);
    chk("mrst_data", {o_pc, o_immd, o_rd1}, 0);
    chk("mrst_in_ready", in_ready, 1);

    // widened instance: all-ones rd1 through main and skid
    v2 = 1'b1; rdy2 = 1'b0; d2_pc = 32'h1; d2_rd1 = '1; d2_ex = '1;
    step(0, NONE, 1);
    d2_pc = 32'h2;
    step(0, NONE, 1);
    chk("p_count", o2_count, 2);
    chk("p_main_pc", o2_pc, 32'h1);
    chk("p_main_rd1", o2_rd1, 32'hFFFF_FFFF);
    chk("p_main_ex", o2_ex, 20'hF_FFFF);
    v2 = 1'b0; rdy2 = 1'b1; d2_rd1 = '0; d2_pc = 32'h9;
    step(0, NONE, 1);
    chk("p_skid_pc", o2_pc, 32'h2);
    chk("p_skid_rd1", o2_rd1, 32'hFFFF_FFFF);
    chk("p_skid_count", o2_count, 1);

    step(0, NONE, 1);
    chk("queue_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
